// File: rtl/oam_dma_controller_if.sv
// CPU snoop, MMU read port and OAM write port of the sprite-attribute DMA.
// master = the DMA engine, slave = the surrounding MMU/CPU/OAM side.
interface oam_dma_controller_if;
  logic        iCpuWe;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic [7:0]  oDmaRegister;
  logic        oDmaActive;
  logic        oDmaReadRequest;
  logic [15:0] oDmaAddr;
  logic [7:0]  iDmaReadData;
  logic        oOamWe;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;

  modport master (
    input  iCpuWe, iCpuAddr, iCpuData, iDmaReadData,
    output oDmaRegister, oDmaActive, oDmaReadRequest, oDmaAddr,
           oOamWe, oOamAddr, oOamData
  );

  modport slave (
    output iCpuWe, iCpuAddr, iCpuData, iDmaReadData,
    input  oDmaRegister, oDmaActive, oDmaReadRequest, oDmaAddr,
           oOamWe, oOamAddr, oOamData
  );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a write to 0xFF46 copies OAM_BYTES bytes from {SRC,00..} into OAM.
// All outputs are registers loaded from the next-state decode.
module oam_dma_controller #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned START_DELAY  = 4,
  parameter int unsigned OAM_BYTES    = 160
) (
  input logic                  iClock,
  input logic                  iReset,
  oam_dma_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  reg_q, reg_d;
  logic        active_q, active_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;
  logic        trigger;

  assign trigger = bus.iCpuWe && (bus.iCpuAddr == 16'hFF46);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    src_d      = src_q;
    reg_d      = reg_q;
    addr_d     = addr_q;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;

    case (state_q)
      S_START: begin
        if (cnt_q == 8'(START_DELAY - 1)) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == 8'(READ_LATENCY - 1)) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (idx_q == 8'(OAM_BYTES - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A trigger overrides whatever the current transfer would do next.
    if (trigger) begin
      reg_d   = bus.iCpuData;
      src_d   = (bus.iCpuData < 8'hE0) ? bus.iCpuData : bus.iCpuData - 8'h20;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = S_START;
    end

    if (state_d == S_READ) begin
      addr_d = {src_d, idx_d};
    end
    // Entering WRITE only happens from the last WAIT cycle: capture the read byte.
    if (state_d == S_WRITE) begin
      oam_addr_d = idx_d;
      oam_data_d = bus.iDmaReadData;
    end

    active_d = (state_d != S_IDLE);
    req_d    = (state_d == S_READ);
    we_d     = (state_d == S_WRITE);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      src_q      <= '0;
      reg_q      <= '0;
      active_q   <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      reg_q      <= reg_d;
      active_q   <= active_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
    end
  end

  assign bus.oDmaRegister    = reg_q;
  assign bus.oDmaActive      = active_q;
  assign bus.oDmaReadRequest = req_q;
  assign bus.oDmaAddr        = addr_q;
  assign bus.oOamWe          = we_q;
  assign bus.oOamAddr        = oam_addr_q;
  assign bus.oOamData        = oam_data_q;

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Bus initiator that performs the sprite-attribute DMA triggered by a CPU write to register 0xFF46 (DMA).
- Sits beside the MMU. Snoops CPU writes, then drives read requests into the MMU memory space for source 0xXX00-0xXX9F.
- Writes each returned byte into OAM index 0x00-0x9F.
- Exposes oDmaActive so the MMU can arbitrate bus/OAM ownership. Exposes the DMA register value for the GPU register read mux.

Parameters:
- READ_LATENCY, 1: clocks from an accepted read request (oDmaReadRequest=1 with oDmaAddr) to valid iDmaReadData. Legal range 1-7.
- START_DELAY, 4: idle clocks between the trigger and the first read (one M-cycle).
- OAM_BYTES, 160: bytes per transfer.

Ports:
- iClock  in  1  system clock; all logic on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCpuWe  in  1  CPU write strobe.
- iCpuAddr  in  16  CPU address.
- iCpuData  in  8  CPU write data.
- oDmaRegister  out  8  last value written to 0xFF46; feeds the GPU DMA register read path.
- oDmaActive  out  1  high from the cycle after the trigger until the cycle after the last OAM write.
- oDmaReadRequest  out  1  one-cycle read strobe into the MMU.
- oDmaAddr  out  16  source read address.
- iDmaReadData  in  8  read data from the MMU.
- oOamWe  out  1  OAM write enable.
- oOamAddr  out  8  OAM byte index 0x00-0x9F.
- oOamData  out  8  OAM write data.

Behaviour:
- Clock and reset: one clock, iClock. Reset iReset is synchronous and active-high.
- Reset values: while iReset=1 at an edge, all outputs go to 0 on that edge (oDmaRegister=0x00, oDmaAddr=0x0000, oOamAddr=0x00, oOamData=0x00). State goes to IDLE, counters clear. Reset mid-transfer aborts with no further OAM writes.
- All outputs are registered.

Trigger:
- Condition: iCpuWe=1 and iCpuAddr=0xFF46 at an edge.
- On that edge: oDmaRegister<=iCpuData.
- Source high byte: SRC = iCpuData if iCpuData<0xE0, else iCpuData-0x20 (echo remap; 0xE0 reads from 0xC0, 0xFF from 0xDF).
- Index is cleared and the state goes to START.

State machine:
- IDLE: no activity. oDmaActive=0.
- START: oDmaActive=1. Holds START_DELAY cycles, then goes to READ.
- READ: one cycle with oDmaReadRequest=1 and oDmaAddr={SRC,index}. Then goes to WAIT.
- WAIT: READ_LATENCY cycles with oDmaReadRequest=0. On the last WAIT cycle, iDmaReadData is captured into the data register. Then goes to WRITE.
- WRITE: one cycle with oOamWe=1, oOamAddr=index, oOamData=captured byte.
  - If index==OAM_BYTES-1: go to IDLE; oDmaActive=0 on the following cycle.
  - Otherwise: index+1, go to READ.

Timing:
- Per byte: READ_LATENCY+2 cycles.
- oDmaActive high for exactly START_DELAY + OAM_BYTES*(READ_LATENCY+2) cycles. Defaults give 4+480=484.
- Index is 8 bits and never exceeds 0x9F; oDmaAddr low byte equals index. No carry into the high byte.

Boundary conditions:
- Retrigger: a 0xFF46 write while active restarts the transfer at the same edge. New SRC, index=0, state START.
  - If the retrigger edge coincides with a WRITE cycle, that OAM write still completes (it was registered on the prior edge). No further bytes of the old transfer are written.
- Writes to other addresses while active are ignored by this block.
- Reset and trigger on the same edge: reset wins.
- oOamWe is never high outside the WRITE state. oDmaReadRequest is never high outside the READ state.

Test Plan:
- Basic transfer: memory model with data=addr[7:0]^0x5A, READ_LATENCY=1. Write 0xFF46=0xC0 at edge k.
  - oDmaActive=1 from cycle k+1 through k+484.
  - First oDmaAddr=0xC000 at cycle k+5.
  - 160 OAM writes, oOamAddr 0x00..0x9F, oOamData=index^0x5A.
  - oDmaRegister=0xC0.
- Echo remap: write 0xFF46=0xE3 -> read addresses 0xC300..0xC39F; oDmaRegister=0xE3.
- Latency sweep: READ_LATENCY=3, source 0x80 -> 5 cycles per byte, oDmaActive high for 804 cycles, OAM data correct.
- Retrigger: write 0xC0, then write 0xD0 after 10 OAM writes.
  - Index restarts at 0x00, next reads are 0xD000.
  - Total writes observed = 10+160. Final OAM contents come from 0xD0xx.
- Reset mid-transfer: assert iReset after index 0x40.
  - Next cycle all outputs are 0, oDmaActive=0, no further oOamWe.
  - A new trigger after reset runs a full 484-cycle transfer.
- Non-trigger writes: writes to 0xFF45, 0xFF47, 0xFE46 -> no activity, oDmaRegister unchanged.
